// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: state codes, trap cause
// codes and their widths. The decoder and the trap logic use these as well.
package ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int CAUSE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_WRITE_BACK = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_TRAP       = 3'd5,
    ST_UNIT_WAIT  = 3'd6
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_ILLEGAL = 3'd1,
    CAUSE_MEM_TO  = 3'd2,
    CAUSE_UNIT_TO = 3'd3,
    CAUSE_IRQ     = 3'd4
  } cause_t;

  // True for the two states in which the watchdog counter runs.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_MEM_WAIT) || (s == ST_UNIT_WAIT);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state watchdog counter: clears on entry to a wait state, counts each
// cycle spent waiting, saturates at all-ones and flags the timeout limit.
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  // Count value on the last allowed wait cycle; unused when the watchdog is off.
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  // Counter register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset || clear) begin
      cnt <= '0;
    end else if (active && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Timeout flag for the current wait cycle.
  always_comb begin
    expired = (TIMEOUT_CYCLES > 0) && (cnt == LIMIT);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: sequences fetch, decode, execute and
// write-back, waits on memory or functional units under a watchdog, and
// raises traps for illegal instructions, timeouts and interrupts.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int NUM_UNITS      = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_busy,
  input  logic                 decoder_illegal,
  input  logic                 is_load_store,
  input  logic                 mem_busy,
  input  logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_busy,
  input  logic                 irq_pending,
  input  logic                 irq_enable,
  output logic [STATE_W-1:0]   state,
  output logic [NUM_UNITS-1:0] unit_sel,
  output logic [CAUSE_W-1:0]   trap_cause,
  output logic                 trap_pulse,
  output logic                 retire_pulse,
  output logic [CNT_W-1:0]     wait_cnt
);

  state_t               state_q;
  state_t               state_d;
  cause_t               cause_d;
  cause_t               trap_cause_q;
  logic [NUM_UNITS-1:0] unit_sel_q;
  logic [NUM_UNITS-1:0] start_onehot;
  logic                 sel_busy;
  logic                 timer_clear;
  logic                 timer_active;
  logic                 timer_expired;

  // Lowest-index start request as one-hot; busy of the unit being waited on.
  always_comb begin
    start_onehot = unit_start & (~unit_start + NUM_UNITS'(1));
    sel_busy     = |(unit_busy & unit_sel_q);
  end

  wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .active  (timer_active),
    .cnt     (wait_cnt),
    .expired (timer_expired)
  );

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and trap-cause selection.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = ST_FETCH;
    cause_d = CAUSE_NONE;
    case (state_q)
      ST_FETCH: begin
        if (irq_pending && irq_enable) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IRQ;
        end else if (fetch_busy) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (decoder_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (|unit_start)        state_d = ST_UNIT_WAIT;
        else if (is_load_store) state_d = ST_MEM_WAIT;
        else                    state_d = ST_WRITE_BACK;
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = ST_WRITE_BACK;
        end else if (timer_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_MEM_TO;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_UNIT_WAIT: begin
        if (!sel_busy) begin
          state_d = ST_WRITE_BACK;
        end else if (timer_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_UNIT_TO;
        end else begin
          state_d = ST_UNIT_WAIT;
        end
      end
      ST_WRITE_BACK: state_d = ST_FETCH;
      ST_TRAP:       state_d = ST_FETCH;
      default:       state_d = ST_FETCH;
    endcase
  end

  // Outputs and timer controls decoded from the current state.
  always_comb begin
    state        = state_q;
    unit_sel     = unit_sel_q;
    trap_cause   = trap_cause_q;
    trap_pulse   = (state_q == ST_TRAP);
    retire_pulse = (state_q == ST_WRITE_BACK);
    timer_clear  = (state_q == ST_EXECUTE) && is_wait_state(state_d);
    timer_active = is_wait_state(state_q);
  end

  // Unit selection latched in EXECUTE; trap cause captured on entry to TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      unit_sel_q   <= '0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      if (state_q == ST_EXECUTE) unit_sel_q <= start_onehot;
      if (state_d == ST_TRAP)    trap_cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a behavioural model checked every
// cycle on two configurations (watchdog of 8 cycles, and watchdog disabled
// with a 3-bit counter), plus directed literal expectations.
module tb_multicycle_ctrl;

  localparam int NU = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_busy, decoder_illegal, is_load_store, mem_busy;
  logic [NU-1:0] unit_start, unit_busy;
  logic          irq_pending, irq_enable;

  logic [2:0]    a_state, b_state;
  logic [NU-1:0] a_sel, b_sel;
  logic [2:0]    a_cause, b_cause;
  logic          a_trap, b_trap, a_ret, b_ret;
  logic [3:0]    a_cnt;
  logic [2:0]    b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .fetch_busy(fetch_busy),
    .decoder_illegal(decoder_illegal), .is_load_store(is_load_store),
    .mem_busy(mem_busy), .unit_start(unit_start), .unit_busy(unit_busy),
    .irq_pending(irq_pending), .irq_enable(irq_enable),
    .state(a_state), .unit_sel(a_sel), .trap_cause(a_cause),
    .trap_pulse(a_trap), .retire_pulse(a_ret), .wait_cnt(a_cnt));

  multicycle_ctrl #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(0), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .fetch_busy(fetch_busy),
    .decoder_illegal(decoder_illegal), .is_load_store(is_load_store),
    .mem_busy(mem_busy), .unit_start(unit_start), .unit_busy(unit_busy),
    .irq_pending(irq_pending), .irq_enable(irq_enable),
    .state(b_state), .unit_sel(b_sel), .trap_cause(b_cause),
    .trap_pulse(b_trap), .retire_pulse(b_ret), .wait_cnt(b_cnt));

  // ---------------- behavioural model ----------------
  // Phase numbers: 0 fetch, 1 decode, 2 execute, 3 write-back,
  // 4 memory wait, 5 trap, 6 unit wait.
  typedef struct {
    int ph;
    int cnt;
    int sel;
    int cause;
  } mdl_t;

  mdl_t ma, mb;
  bit   model_valid = 0;

  function automatic mdl_t model_step(mdl_t m, int tmo, int cmax);
    mdl_t n = m;
    int   busy;
    if (reset) begin
      n.ph = 0; n.cnt = 0; n.sel = 0; n.cause = 0;
      return n;
    end
    case (m.ph)
      0: if (irq_pending && irq_enable) begin n.ph = 5; n.cause = 4; end
         else if (!fetch_busy) n.ph = 1;
      1: if (decoder_illegal) begin n.ph = 5; n.cause = 1; end
         else n.ph = 2;
      2: begin
        n.sel = 0;
        for (int i = NU - 1; i >= 0; i--) if (unit_start[i]) n.sel = 1 << i;
        if (n.sel != 0)         begin n.ph = 6; n.cnt = 0; end
        else if (is_load_store) begin n.ph = 4; n.cnt = 0; end
        else n.ph = 3;
      end
      4, 6: begin
        busy = (m.ph == 4) ? int'(mem_busy) : int'((unit_busy & m.sel[NU-1:0]) != 0);
        if (busy == 0) n.ph = 3;
        else if (tmo > 0 && m.cnt == tmo - 1) begin
          n.ph = 5; n.cause = (m.ph == 4) ? 2 : 3;
        end
        n.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
      end
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= model_step(ma, 8, 15);
    mb <= model_step(mb, 0, 7);
    if (reset) model_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("a.state", 32'(a_state), ma.ph);
      check("a.unit_sel", 32'(a_sel), ma.sel);
      check("a.trap_cause", 32'(a_cause), ma.cause);
      check("a.trap_pulse", 32'(a_trap), 32'(ma.ph == 5));
      check("a.retire_pulse", 32'(a_ret), 32'(ma.ph == 3));
      if (ma.ph == 4 || ma.ph == 6) check("a.wait_cnt", 32'(a_cnt), ma.cnt);
      check("b.state", 32'(b_state), mb.ph);
      check("b.unit_sel", 32'(b_sel), mb.sel);
      check("b.trap_cause", 32'(b_cause), mb.cause);
      check("b.trap_pulse", 32'(b_trap), 32'(mb.ph == 5));
      check("b.retire_pulse", 32'(b_ret), 32'(mb.ph == 3));
      if (mb.ph == 4 || mb.ph == 6) check("b.wait_cnt", 32'(b_cnt), mb.cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_busy = 0; decoder_illegal = 0; is_load_store = 0; mem_busy = 0;
    unit_start = '0; unit_busy = '0; irq_pending = 0; irq_enable = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 1_000_000);
    $fatal(1);
  end

  initial begin
    reset = 1;
    clear_inputs();
    do_reset();

    // Reset state
    check("rst state", 32'(a_state), 0);
    check("rst unit_sel", 32'(a_sel), 0);
    check("rst trap_cause", 32'(a_cause), 0);
    check("rst wait_cnt", 32'(a_cnt), 0);
    check("rst pulses", {30'd0, a_trap, a_ret}, 0);

    // ALU op: 0,1,2,3,0 with retire only in the fourth cycle
    step(); check("alu decode", 32'(a_state), 1);
    step(); check("alu execute", 32'(a_state), 2);
    check("alu no retire early", 32'(a_ret), 0);
    step(); check("alu write_back", 32'(a_state), 3);
    check("alu retire", 32'(a_ret), 1);
    step(); check("alu back fetch", 32'(a_state), 0);
    check("alu retire drop", 32'(a_ret), 0);

    // Unit op: both starts, unit 0 busy 3 cycles, unit 1 held busy
    unit_start = 2'b11;
    step(); step();
    unit_busy = 2'b11;
    step(); check("unit wait1", 32'(a_state), 6);
    check("unit sel lowest", 32'(a_sel), 32'h1);
    check("unit cnt0", 32'(a_cnt), 0);
    step(); check("unit wait2", 32'(a_state), 6);
    step(); check("unit wait3", 32'(a_state), 6);
    check("unit cnt2", 32'(a_cnt), 2);
    unit_busy = 2'b10;
    step(); check("unit write_back", 32'(a_state), 3);
    check("unit sel held", 32'(a_sel), 32'h1);
    unit_start = '0; unit_busy = '0;
    step(); step(); step(); step();
    check("alu2 write_back", 32'(a_state), 3);
    check("unit sel cleared", 32'(a_sel), 0);
    step();

    // Load with mem_busy stuck: trap after 8 waits (a); saturation (b)
    do_reset();
    is_load_store = 1; mem_busy = 1;
    step(); step(); step();
    check("ld mem_wait", 32'(a_state), 4);
    for (int i = 0; i < 7; i++) step();
    check("ld cnt7", 32'(a_cnt), 7);
    check("ld still waiting", 32'(a_state), 4);
    step(); check("ld trap", 32'(a_state), 5);
    check("ld trap cause", 32'(a_cause), 2);
    check("ld trap pulse", 32'(a_trap), 1);
    check("nowd still waiting", 32'(b_state), 4);
    check("nowd cnt7", 32'(b_cnt), 7);
    step(); check("ld trap to fetch", 32'(a_state), 0);
    check("ld pulse one cycle", 32'(a_trap), 0);
    check("ld cause holds", 32'(a_cause), 2);
    step(); step();
    check("nowd saturated", 32'(b_cnt), 7);
    mem_busy = 0;
    step(); check("nowd write_back", 32'(b_state), 3);

    // Illegal trap, then busy falls exactly at the last allowed cycle
    do_reset();
    decoder_illegal = 1;
    step(); step();
    check("ill trap", 32'(a_state), 5);
    check("ill cause", 32'(a_cause), 1);
    decoder_illegal = 0;
    step();
    is_load_store = 1; mem_busy = 1;
    step(); step(); step();
    for (int i = 0; i < 7; i++) step();
    check("race cnt7", 32'(a_cnt), 7);
    mem_busy = 0;
    step(); check("race write_back", 32'(a_state), 3);
    check("race cause unchanged", 32'(a_cause), 1);
    check("race no trap", 32'(a_trap), 0);

    // Interrupt in FETCH while fetch is busy
    do_reset();
    fetch_busy = 1; irq_pending = 1; irq_enable = 0;
    step(); check("irq masked", 32'(a_state), 0);
    irq_enable = 1;
    step(); check("irq trap", 32'(a_state), 5);
    check("irq cause", 32'(a_cause), 4);
    step(); check("irq back fetch", 32'(a_state), 0);
    clear_inputs();

    // Reset during UNIT_WAIT aborts without pulses
    do_reset();
    unit_start = 2'b01; unit_busy = 2'b01;
    step(); step(); step(); step();
    check("rw wait", 32'(a_state), 6);
    check("rw cnt1", 32'(a_cnt), 1);
    reset = 1;
    step();
    check("rw state", 32'(a_state), 0);
    check("rw cnt", 32'(a_cnt), 0);
    check("rw sel", 32'(a_sel), 0);
    check("rw pulses", {30'd0, a_trap, a_ret}, 0);
    reset = 0;
    clear_inputs();
    step(); check("rw restart", 32'(a_state), 1);
    check("rw no retire", 32'(a_ret), 0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter NUM_UNITS, default 2: number of multi-cycle functional units (e.g. div, mul), range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: wait-state watchdog limit in cycles; 0 disables the watchdog.
REQ-003 Parameter CNT_W, default 9: wait-counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-004 One clock; reset is synchronous and active-high (ports clk, reset).
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 fetch_busy  in  1  instruction fetch not yet complete.
REQ-008 decoder_illegal  in  1  decoded instruction is illegal.
REQ-009 is_load_store  in  1  current instruction is a load or store.
REQ-010 mem_busy  in  1  data memory access in progress.
REQ-011 unit_start  in  NUM_UNITS  per-unit start request, sampled in EXECUTE.
REQ-012 unit_busy  in  NUM_UNITS  per-unit busy.
REQ-013 irq_pending, irq_enable  in  1 each  external interrupt request and global enable.
REQ-014 state  out  3  current state.
REQ-015 unit_sel  out  NUM_UNITS  one-hot latched unit being waited on.
REQ-016 trap_cause  out  3  cause code of the most recent trap.
REQ-017 trap_pulse  out  1  high for exactly the cycle spent in TRAP.
REQ-018 retire_pulse  out  1  high for exactly the cycle spent in WRITE_BACK.
REQ-019 wait_cnt  out  CNT_W  cycles elapsed in the current wait state.

Function
REQ-020 States: FETCH=0, DECODE=1, EXECUTE=2, WRITE_BACK=3, MEM_WAIT=4, TRAP=5, UNIT_WAIT=6; code 7 is illegal and goes to FETCH.
REQ-021 FETCH: irq_pending&irq_enable -> TRAP with cause IRQ (takes priority over fetch_busy); else fetch_busy -> stay in FETCH; else -> DECODE.
REQ-022 DECODE: decoder_illegal -> TRAP with cause ILLEGAL; else -> EXECUTE.
REQ-023 EXECUTE: any unit_start bit set -> UNIT_WAIT, latch unit_sel to the lowest-index set bit; else is_load_store -> MEM_WAIT; else -> WRITE_BACK.
REQ-024 UNIT_WAIT: stays while unit_busy[index of unit_sel]; other units' busy bits are ignored; on deassertion -> WRITE_BACK.
REQ-025 MEM_WAIT: stays while mem_busy; on deassertion -> WRITE_BACK.
REQ-026 wait_cnt clears to 0 on every transition into MEM_WAIT or UNIT_WAIT, increments each cycle spent in the wait state, and saturates at all-ones.
REQ-027 Watchdog (TIMEOUT_CYCLES>0): in a wait state with busy still high and wait_cnt==TIMEOUT_CYCLES-1 -> TRAP with cause MEM_TO or UNIT_TO; busy falling in the same cycle wins, giving WRITE_BACK.
REQ-028 WRITE_BACK -> FETCH; TRAP -> FETCH, each in 1 cycle.
REQ-029 Cause codes: NONE=0, ILLEGAL=1, MEM_TO=2, UNIT_TO=3, IRQ=4. trap_cause updates on entry to TRAP and holds until the next trap.
REQ-030 unit_sel holds its value until the next EXECUTE that has a unit start; it is 0 after an EXECUTE with no start.
REQ-031 Minimum latencies: ALU op 4 cycles FETCH..WRITE_BACK; load/store or unit op with zero busy cycles 5 cycles.

Reset
REQ-032 Reset gives state=FETCH, unit_sel=0, trap_cause=NONE, wait_cnt=0, and trap_pulse=retire_pulse=0 on the next edge.
REQ-033 Reset asserted in any state, including mid-wait, aborts the operation; no retire_pulse or trap_pulse is emitted for it.

Structure
REQ-034 State encodings, cause codes and widths shall live in a shared package, ctrl_pkg, which the decoder and trap logic also use.
REQ-035 The watchdog counter (clear, increment, saturate, compare) shall be a sub-module, wait_timer.

Verification
REQ-036 ALU op, all busy low: states 0,1,2,3,0; retire_pulse high in cycle 4 only.
REQ-037 unit_start=2'b11, unit_busy[0] high for 3 cycles, unit_busy[1] held high: unit_sel=2'b01, 3 UNIT_WAIT cycles, then WRITE_BACK.
REQ-038 Load with mem_busy stuck high, TIMEOUT_CYCLES=8: TRAP after 8 MEM_WAIT cycles, trap_cause=2, trap_pulse for 1 cycle.
REQ-039 mem_busy falls in the same cycle wait_cnt==7: WRITE_BACK, not TRAP; trap_cause unchanged.
REQ-040 irq_pending=1 with irq_enable=1 in FETCH while fetch_busy=1: TRAP next cycle with cause 4; with irq_enable=0 the interrupt is ignored.
REQ-041 Reset pulsed during UNIT_WAIT: FETCH next cycle, wait_cnt=0, unit_sel=0, no pulses.
